nfsr_keystream_ctrl: RTL and testbench
======================================

# nfsr_keystream_ctrl

Sequencer for the 24-bit `nfsr` keystream register. On a start command it:

- parallel-loads a seed into the `nfsr`;
- runs a fixed warm-up of discarded shifts;
- packs a requested number of keystream words from `Ser_out` into parallel words;
- delivers those words to a consumer over a valid/ready handshake.

The `nfsr` shifts only when this block enables it, so consumer back-pressure stalls the generator without losing bits.

## Interface
- `WARMUP`, 48, number of discarded shifts after seed load (≥1).
- `WORD_W`, 8, keystream bits per output word (≥2).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: terminate the current run.
- `seed` in 24: seed, captured when `start` is accepted.
- `num_words` in 8: words to produce, captured when `start` is accepted.
- `out_ready` in 1: consumer accepts `out_word`.
- `nfsr_ser_out` in 1: `Ser_out` of the `nfsr`.
- `nfsr_shift_en` out 1: to `nfsr` `shift_en`.
- `nfsr_par_load` out 1: to `nfsr` `Par_load`.
- `nfsr_seed` out 24: to `nfsr` `Seed`; the captured seed register.
- `out_word` out WORD_W: keystream word.
- `out_valid` out 1: `out_word` is valid.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the run completes normally.

## Operation
- Reset: state=IDLE; all outputs 0, including `nfsr_seed`, `out_word` and `out_valid`; all counters 0.
- FSM states: IDLE, LOAD, WARMUP, STREAM, DONE.
- IDLE:
  - `start`=1 and `num_words`≠0: capture `seed` and `num_words`, go to LOAD.
  - `start` with `num_words`=0 is ignored.
- LOAD: `nfsr_par_load`=1 for exactly one cycle; go to WARMUP.
- WARMUP:
  - `nfsr_shift_en`=1 for exactly `WARMUP` cycles; bits discarded.
  - Then go to STREAM.
- STREAM, assembler:
  - Holds a `WORD_W` shift register `asm` and bit count `bc`.
  - `nfsr_shift_en`=1 iff `bc`<`WORD_W` and words assembled < captured `num_words`.
  - On each shift edge, `nfsr_ser_out` (the pre-shift value) enters `asm` at the LSB and existing bits move toward the MSB, so the first captured bit ends up in the MSB. `bc` increments.
- STREAM, transfer:
  - When `bc`=`WORD_W` and (`out_valid`=0 or `out_ready`=1), the next edge copies `asm` to `out_word`, sets `out_valid`, clears `bc`, and increments the assembled count.
  - No shifting occurs in the transfer cycle.
- Handshake:
  - A word is consumed on an edge with `out_valid`&`out_ready`.
  - `out_valid` clears on that edge unless a new transfer happens on the same edge.
  - `out_word` is stable while `out_valid`=1 and `out_ready`=0.
- Back-pressure: a full assembler with an unconsumed output word holds `nfsr_shift_en`=0 indefinitely. No bit is lost or duplicated.
- Completion: when the final word is consumed, go to DONE. DONE asserts `done`=1 for one cycle, then goes to IDLE.
- `abort`=1, any state except IDLE:
  - Next state is IDLE.
  - `out_valid`, `bc` and counters clear; `nfsr_shift_en`/`nfsr_par_load` go to 0 from the next cycle.
  - No `done` pulse.
- `abort` and `start` together in IDLE: `abort` wins; the run does not start.
- `start` while `busy` is ignored.
- `rst` has priority over everything.
- `nfsr_shift_en` and `nfsr_par_load` are never high in the same cycle.

## Timing
- Edge E0 accepts `start`.
  - `nfsr_par_load` high between E0 and E1.
  - Warm-up shifts occur on E2..E(WARMUP+1).
  - Stream shifts for word 1 occur on E(WARMUP+2)..E(WARMUP+WORD_W+1).
  - Transfer occurs on E(WARMUP+WORD_W+2).
  - With defaults, `out_valid` is first high after E58.
- With `out_ready` held 1, one word per `WORD_W`+1 cycles; 9 cycles with defaults.
- Total shift cycles per completed run = `WARMUP` + `WORD_W`·`num_words`, independent of stalls.
- `done` is high in the cycle after the edge that consumed the last word.
- `busy` rises after E0 and falls after the DONE cycle.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst`=1 for 3 cycles, then pulse `start` with `num_words`=0.
  - Required: all outputs stay 0 and `busy` stays 0.
- Basic run:
  - Stimulus: `seed`=24'h123456, `num_words`=3, `out_ready`=1.
  - Required: one `nfsr_par_load` pulse; `nfsr_seed`=24'h123456; exactly 72 `nfsr_shift_en` cycles; 3 handshakes, the first at E58 and then every 9 cycles; one `done` pulse.
- Bit packing:
  - Stimulus: a stub `nfsr` drives `nfsr_ser_out` = 1,0,1,1,0,0,1,0 on the first 8 stream shifts.
  - Required: first `out_word`=8'hB2. Warm-up bits do not appear in `out_word`.
- Back-pressure:
  - Stimulus: `num_words`=2, `out_ready`=0 for 30 cycles after the first `out_valid`, then 1.
  - Required: `out_word` stays stable while stalled; shifting stops after word 2 is assembled; still exactly 64 total shifts; both words are delivered in order.
- Abort:
  - Stimulus: assert `abort` during WARMUP and, separately, during a stalled STREAM.
  - Required: IDLE next cycle; `out_valid`=0; no `done` pulse; a subsequent `start` runs a full correct sequence.
- Start while busy:
  - Stimulus: pulse `start` with a different `seed` mid-run.
  - Required: the pulse is ignored and `nfsr_seed` is unchanged.

Source files
------------

// File: rtl/nfsr_keystream_ctrl.sv
// Sequencer for the 24-bit nfsr keystream register: seed load, discarded warm-up,
// MSB-first word packing from Ser_out, and valid/ready delivery with back-pressure.
module nfsr_keystream_ctrl #(
   parameter int WARMUP = 48,
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [23:0]       seed,
   input  logic [7:0]        num_words,
   input  logic              out_ready,
   input  logic              nfsr_ser_out,
   output logic              nfsr_shift_en,
   output logic              nfsr_par_load,
   output logic [23:0]       nfsr_seed,
   output logic [WORD_W-1:0] out_word,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int BC_W = $clog2(WORD_W + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(WARMUP - 1);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WARMUP,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t            state;
   logic [WC_W-1:0]   wcnt;
   logic [BC_W-1:0]   bc;
   logic [WORD_W-1:0] asm_q;
   logic [7:0]        asm_cnt;
   logic [7:0]        num_q;

   logic              shifting;
   logic              consume;
   logic              transfer;
   logic              last_taken;
   logic [BC_W-1:0]   bc_nxt;
   logic [7:0]        asm_cnt_nxt;

   // Look-ahead terms shared by the assembler and the registered shift enable.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      shifting    = 1'b0;
      consume     = out_valid && out_ready;
      transfer    = 1'b0;
      last_taken  = 1'b0;
      bc_nxt      = bc;
      asm_cnt_nxt = asm_cnt;
      if (state == ST_STREAM) begin
         shifting   = nfsr_shift_en;
         transfer   = (bc == BC_FULL) && (!out_valid || out_ready);
         last_taken = consume && (asm_cnt == num_q);
         if (transfer) begin
            bc_nxt      = '0;
            asm_cnt_nxt = asm_cnt + 8'd1;
         end else if (shifting) begin
            bc_nxt = bc + BC_W'(1);
         end
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         wcnt          <= '0;
         bc            <= '0;
         asm_q         <= '0;
         asm_cnt       <= '0;
         num_q         <= '0;
         nfsr_shift_en <= 1'b0;
         nfsr_par_load <= 1'b0;
         nfsr_seed     <= '0;
         out_word      <= '0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else if (abort && (state != ST_IDLE)) begin
         state         <= ST_IDLE;
         wcnt          <= '0;
         bc            <= '0;
         asm_cnt       <= '0;
         nfsr_shift_en <= 1'b0;
         nfsr_par_load <= 1'b0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort && (num_words != 8'd0)) begin
                  nfsr_seed     <= seed;
                  num_q         <= num_words;
                  asm_cnt       <= '0;
                  bc            <= '0;
                  nfsr_par_load <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               nfsr_par_load <= 1'b0;
               nfsr_shift_en <= 1'b1;
               wcnt          <= '0;
               state         <= ST_WARMUP;
            end

            // Shift enable stays high straight into STREAM: num_q is never zero here.
            ST_WARMUP: begin
               if (wcnt == WC_LAST) begin
                  bc    <= '0;
                  state <= ST_STREAM;
               end else begin
                  wcnt <= wcnt + WC_W'(1);
               end
            end

            ST_STREAM: begin
               if (shifting) begin
                  asm_q <= {asm_q[WORD_W-2:0], nfsr_ser_out};
               end
               if (transfer) begin
                  out_word  <= asm_q;
                  out_valid <= 1'b1;
               end else if (consume) begin
                  out_valid <= 1'b0;
               end
               bc            <= bc_nxt;
               asm_cnt       <= asm_cnt_nxt;
               nfsr_shift_en <= (bc_nxt < BC_FULL) && (asm_cnt_nxt < num_q);
               if (last_taken) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               nfsr_shift_en <= 1'b0;
               nfsr_par_load <= 1'b0;
               busy          <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nfsr_keystream_ctrl.sv
// Bench for nfsr_keystream_ctrl: a counter-indexed nfsr stub, a table of directed runs,
// and hand-written sequences for reset, bit packing, abort and start-while-busy.
module tb_nfsr_keystream_ctrl;

   localparam int WARM = 48;
   localparam int WW   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] seed = '0;
   logic [7:0]  num_words = '0;
   logic        nfsr_ser_out;
   logic        nfsr_shift_en;
   logic        nfsr_par_load;
   logic [23:0] nfsr_seed;
   logic [7:0]  out_word;
   logic        out_valid;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   bit pat_mode = 1'b0;
   logic [7:0] first_word_g = '0;

   always #5 clk = ~clk;

   nfsr_keystream_ctrl #(.WARMUP(WARM), .WORD_W(WW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .seed          (seed),
      .num_words     (num_words),
      .out_ready     (out_ready),
      .nfsr_ser_out  (nfsr_ser_out),
      .nfsr_shift_en (nfsr_shift_en),
      .nfsr_par_load (nfsr_par_load),
      .nfsr_seed     (nfsr_seed),
      .out_word      (out_word),
      .out_valid     (out_valid),
      .busy          (busy),
      .done          (done)
   );

   // Stub bit n of the keystream after a load of seed s (pattern mode: warm-up all ones, then B2 MSB first).
   function automatic logic stub_bit(input logic [23:0] s, input int n, input bit pat);
      logic [7:0] p;
      int j;
      p = 8'hB2;
      if (pat) begin
         if (n < WARM) return 1'b1;
         j = n - WARM;
         if (j < 8) return p[7-j];
         return 1'b0;
      end
      return s[n % 24] ^ n[3] ^ (n[0] & n[5]);
   endfunction

   function automatic logic [7:0] exp_word(input logic [23:0] s, input int idx, input bit pat);
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < WW; i++) w = {w[6:0], stub_bit(s, WARM + WW * idx + i, pat)};
      return w;
   endfunction

   logic [23:0] stub_seed = '0;
   int          stub_cnt = 0;
   always @(posedge clk) begin
      if (nfsr_par_load) begin
         stub_seed <= nfsr_seed;
         stub_cnt  <= 0;
      end else if (nfsr_shift_en) begin
         stub_cnt <= stub_cnt + 1;
      end
   end
   assign nfsr_ser_out = stub_bit(stub_seed, stub_cnt, pat_mode);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [23:0] seed;
      logic [7:0]  num;
      int          stall;
      bit          mid_start;
      bit          pat;
      int          exp_shifts;
      int          exp_first_valid;
      int          exp_done_k;
      int          exp_rel_shifts;
   } vec_t;

   vec_t vecs[5];
   vec_t pat_vec;

   // k counts edges after E0; observations at the falling edge after Ek.
   task automatic run_vec(input int id, input vec_t v);
      string tag;
      int shifts = 0, pars = 0, hs = 0, word_err = 0, done_cnt = 0, overlap = 0;
      int first_valid = -1, done_k = -1, last_hs_k = -1, int_bad = 0, stall_bad = 0, rel_shifts = -1;
      bit busy0 = 1'b0, finished = 1'b0, stalling;
      tag = $sformatf("v%0d", id);
      pat_mode = v.pat;
      @(negedge clk);
      seed = v.seed;
      num_words = v.num;
      abort = 1'b0;
      start = 1'b1;
      out_ready = (v.stall == 0);
      @(posedge clk);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 0) busy0 = busy;
         if (nfsr_par_load) pars++;
         if (nfsr_shift_en) shifts++;
         if (nfsr_par_load && nfsr_shift_en) overlap++;
         if (done) begin
            done_cnt++;
            done_k = k;
         end
         if (out_valid && first_valid < 0) first_valid = k;
         stalling = (v.stall > 0) && (first_valid < 0 || k < first_valid + v.stall);
         out_ready = !stalling;
         if (out_valid) begin
            if (out_ready) begin
               if (hs < int'(v.num)) begin
                  if (out_word !== exp_word(v.seed, hs, v.pat)) word_err++;
               end else begin
                  word_err++;
               end
               if (hs == 0) first_word_g = out_word;
               if (last_hs_k >= 0 && (k - last_hs_k) != WW + 1) int_bad++;
               last_hs_k = k;
               hs++;
            end else if (out_word !== exp_word(v.seed, hs, v.pat)) begin
               stall_bad++;
            end
         end
         if (v.stall > 0 && first_valid >= 0 && k == first_valid + v.stall - 1) rel_shifts = shifts;
         if (v.mid_start && k == 20) begin
            start = 1'b1;
            seed = ~v.seed;
            num_words = 8'd9;
         end
         if (done_k >= 0 && !busy) begin
            finished = 1'b1;
            break;
         end
      end
      check({tag, "_finished"}, finished, 1);
      check({tag, "_busy_after_e0"}, busy0, 1);
      check({tag, "_par_pulses"}, pars, 1);
      check({tag, "_seed"}, nfsr_seed, v.seed);
      check({tag, "_shifts"}, shifts, v.exp_shifts);
      check({tag, "_handshakes"}, hs, v.num);
      check({tag, "_word_errors"}, word_err, 0);
      check({tag, "_first_valid_k"}, first_valid, v.exp_first_valid);
      check({tag, "_done_k"}, done_k, v.exp_done_k);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_load_shift_overlap"}, overlap, 0);
      if (v.stall == 0) begin
         check({tag, "_interval"}, int_bad, 0);
      end else begin
         check({tag, "_stall_stable"}, stall_bad, 0);
         check({tag, "_shifts_at_release"}, rel_shifts, v.exp_rel_shifts);
      end
   endtask

   task automatic start_run(input logic [23:0] s, input logic [7:0] n, input logic rdy);
      @(negedge clk);
      seed = s;
      num_words = n;
      out_ready = rdy;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic watch_idle(input string name, input int cycles);
      int bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done || busy || nfsr_shift_en || nfsr_par_load || out_valid) bad++;
      end
      check(name, bad, 0);
   endtask

   initial begin
      //             seed        num  stall mid pat shifts fv  done rel
      vecs[0] = '{24'h123456, 8'd3, 0,  1'b0, 1'b0, 72, 58, 77, 0};
      vecs[1] = '{24'hABCDEF, 8'd1, 0,  1'b0, 1'b0, 56, 58, 59, 0};
      vecs[2] = '{24'h0F0F0F, 8'd2, 30, 1'b0, 1'b0, 64, 58, 90, 64};
      vecs[3] = '{24'h800001, 8'd5, 0,  1'b0, 1'b0, 88, 58, 95, 0};
      vecs[4] = '{24'h13579B, 8'd2, 0,  1'b1, 1'b0, 64, 58, 68, 0};
      pat_vec = '{24'h000000, 8'd1, 0,  1'b0, 1'b1, 56, 58, 59, 0};

      // Reset, then a start with num_words=0 must be ignored.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {busy, done, out_valid, nfsr_par_load, nfsr_shift_en, out_word, nfsr_seed}, 0);
      rst = 1'b0;
      seed = 24'hFFFFFF;
      num_words = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int bad = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({busy, done, out_valid, nfsr_par_load, nfsr_shift_en, out_word, nfsr_seed} !== '0) bad++;
         end
         check("zero_words_ignored", bad, 0);
      end

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      run_vec(10, pat_vec);
      check("bitpack_first_word", first_word_g, 8'hB2);

      // Abort during warm-up, then a full run.
      start_run(24'h2468AC, 8'd3, 1'b1);
      repeat (10) @(negedge clk);
      check("abw_in_warmup", {busy, nfsr_shift_en}, 2'b11);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abw_idle_next", {busy, out_valid, nfsr_shift_en, nfsr_par_load, done}, 0);
      watch_idle("abw_no_done", 60);
      run_vec(20, vecs[0]);

      // Abort during a stalled stream, then a full run.
      start_run(24'h0BADF0, 8'd2, 1'b0);
      repeat (75) @(negedge clk);
      check("abs_stalled", {out_valid, nfsr_shift_en, busy}, 3'b101);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abs_idle_next", {busy, out_valid, nfsr_shift_en, nfsr_par_load, done}, 0);
      watch_idle("abs_no_done", 40);
      run_vec(21, vecs[2]);

      // abort and start together in IDLE: no run starts and the seed is not captured.
      @(negedge clk);
      seed = 24'h777777;
      num_words = 8'd4;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_idle", {busy, nfsr_par_load}, 0);
      check("abort_start_seed", nfsr_seed, vecs[2].seed);
      watch_idle("abort_start_quiet", 5);

      // Reset mid-run clears everything, including the captured seed and last word.
      start_run(24'hC0FFEE, 8'd2, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_midrun", {busy, done, out_valid, nfsr_par_load, nfsr_shift_en, out_word, nfsr_seed}, 0);
      rst = 1'b0;
      watch_idle("reset_midrun_quiet", 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
